// File: rtl/jtag_pkg.sv
// TAP controller state encoding and instruction constants shared by the JTAG TAP blocks.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  localparam int INSTR_IDCODE  = 1;
  // -1 truncates to all-ones at any IR width.
  localparam int INSTR_BYPASS  = -1;
  localparam int INSTR_DR_BASE = 2;

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with a third flop for
// one-clk rise/fall pulses.
module jtag_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign dout = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP in the clk domain: pin synchronisers, TAP controller, IR,
// BYPASS, IDCODE and NUM_DR user data registers with update shadows.
//
// state            | meaning
// TEST_LOGIC_RESET | idle in reset, IR forced to IDCODE
// RUN_IDLE         | idle between scans
// SELECT_DR/IR     | choose DR or IR column
// CAPTURE_DR/IR    | parallel load of selected shift register
// SHIFT_DR/IR      | serial shift, LSB first, TDO driven
// EXIT1/PAUSE/EXIT2| shift suspended
// UPDATE_DR/IR     | shadow register / IR loaded on tck fall
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 5,
  parameter int          DR_WIDTH     = 32,
  parameter int          NUM_DR       = 2,
  parameter logic [31:0] IDCODE_VALUE = 32'h00000001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         jtag_tck,
  input  logic                         jtag_tms,
  input  logic                         jtag_tdi,
  output logic                         jtag_tdo,
  output logic                         jtag_tdo_en,
  output logic [IR_WIDTH-1:0]          ir_value,
  input  logic [NUM_DR*DR_WIDTH-1:0]   dr_capture_data,
  output logic [NUM_DR*DR_WIDTH-1:0]   dr_update_data,
  output logic [NUM_DR-1:0]            dr_update_strobe
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic tck_sync, tck_rise, tck_fall;
  logic tms_s1, tms_sync, tdi_s1, tdi_sync;

  jtag_sync_edge u_tck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (jtag_tck),
    .dout (tck_sync),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tms_s1   <= 1'b0;
      tms_sync <= 1'b0;
      tdi_s1   <= 1'b0;
      tdi_sync <= 1'b0;
    end else begin
      tms_s1   <= jtag_tms;
      tms_sync <= tms_s1;
      tdi_s1   <= jtag_tdi;
      tdi_sync <= tdi_s1;
    end
  end

  tap_state_e state, state_next;

  always_ff @(posedge clk) begin
    if (rst)           state <= TEST_LOGIC_RESET;
    else if (tck_rise) state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      TEST_LOGIC_RESET: state_next = tms_sync ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         state_next = tms_sync ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:        state_next = tms_sync ? SELECT_IR  : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms_sync ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:         state_next = tms_sync ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:         state_next = tms_sync ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:         state_next = tms_sync ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:         state_next = tms_sync ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:        state_next = tms_sync ? SELECT_DR  : RUN_IDLE;
      SELECT_IR:        state_next = tms_sync ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms_sync ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:         state_next = tms_sync ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:         state_next = tms_sync ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:         state_next = tms_sync ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:         state_next = tms_sync ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:        state_next = tms_sync ? SELECT_DR  : RUN_IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  logic is_tlr, is_capture_dr, is_shift_dr, is_update_dr;
  logic is_capture_ir, is_shift_ir, is_update_ir;

  always_comb begin
    is_tlr        = (state == TEST_LOGIC_RESET);
    is_capture_dr = (state == CAPTURE_DR);
    is_shift_dr   = (state == SHIFT_DR);
    is_update_dr  = (state == UPDATE_DR);
    is_capture_ir = (state == CAPTURE_IR);
    is_shift_ir   = (state == SHIFT_IR);
    is_update_ir  = (state == UPDATE_IR);
  end

  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0]         idcode_sr;
  logic                bypass_sr;
  logic [DR_WIDTH-1:0] user_sr [NUM_DR];
  logic                sel_idcode, sel_bypass;
  logic [NUM_DR-1:0]   sel_user;
  logic                dr_lsb;

  always_comb begin
    sel_idcode = (ir_value == IR_IDCODE);
    for (int k = 0; k < NUM_DR; k++)
      sel_user[k] = (ir_value == IR_WIDTH'(INSTR_DR_BASE + k));
    // Zero and every unassigned opcode fall back to BYPASS.
    sel_bypass = ~sel_idcode & ~(|sel_user);
  end

  always_comb begin
    dr_lsb = bypass_sr;
    if (sel_idcode) dr_lsb = idcode_sr[0];
    for (int k = 0; k < NUM_DR; k++)
      if (sel_user[k]) dr_lsb = user_sr[k][0];
  end

  function automatic logic [DR_WIDTH-1:0] shift_in(logic [DR_WIDTH-1:0] v, logic b);
    logic [DR_WIDTH:0] t;
    t = {b, v};
    return t[DR_WIDTH:1];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_sr            <= '0;
      idcode_sr        <= '0;
      bypass_sr        <= 1'b0;
      for (int k = 0; k < NUM_DR; k++) user_sr[k] <= '0;
      ir_value         <= IR_IDCODE;
      dr_update_data   <= '0;
      dr_update_strobe <= '0;
      jtag_tdo         <= 1'b0;
      jtag_tdo_en      <= 1'b0;
    end else begin
      dr_update_strobe <= '0;
      if (tck_rise) begin
        if (is_capture_ir) ir_sr <= IR_CAPTURE;
        if (is_shift_ir)   ir_sr <= {tdi_sync, ir_sr[IR_WIDTH-1:1]};
        if (sel_idcode && is_capture_dr) idcode_sr <= IDCODE_VALUE;
        if (sel_idcode && is_shift_dr)   idcode_sr <= {tdi_sync, idcode_sr[31:1]};
        if (sel_bypass && is_capture_dr) bypass_sr <= 1'b0;
        if (sel_bypass && is_shift_dr)   bypass_sr <= tdi_sync;
        for (int k = 0; k < NUM_DR; k++) begin
          if (sel_user[k] && is_capture_dr)
            user_sr[k] <= dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
          if (sel_user[k] && is_shift_dr)
            user_sr[k] <= shift_in(user_sr[k], tdi_sync);
        end
      end
      if (tck_fall) begin
        jtag_tdo_en <= is_shift_dr | is_shift_ir;
        if (is_shift_ir)      jtag_tdo <= ir_sr[0];
        else if (is_shift_dr) jtag_tdo <= dr_lsb;
        if (is_update_ir) ir_value <= ir_sr;
        for (int k = 0; k < NUM_DR; k++) begin
          if (is_update_dr && sel_user[k]) begin
            dr_update_data[k*DR_WIDTH +: DR_WIDTH] <= user_sr[k];
            dr_update_strobe[k]                    <= 1'b1;
          end
        end
      end
      if (is_tlr) ir_value <= IR_IDCODE;
    end
  end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Directed-plus-random bench for jtag_tap_core: scans driven through slow TCK,
// expected TDO streams and update values taken from a shift-stream model.
module tb_jtag_tap_core;

  localparam int          IRW = 5;
  localparam int          DRW = 32;
  localparam int          NDR = 2;
  localparam logic [31:0] IDC = 32'h4BA00477;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 jtag_tck, jtag_tms, jtag_tdi;
  logic                 jtag_tdo, jtag_tdo_en;
  logic [IRW-1:0]       ir_value;
  logic [NDR*DRW-1:0]   dr_capture_data;
  logic [NDR*DRW-1:0]   dr_update_data;
  logic [NDR-1:0]       dr_update_strobe;

  int total = 0;
  int bad   = 0;
  int strobe_hi [NDR];
  logic [DRW-1:0] exp_upd [NDR];

  jtag_tap_core #(
    .IR_WIDTH     (IRW),
    .DR_WIDTH     (DRW),
    .NUM_DR       (NDR),
    .IDCODE_VALUE (IDC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .jtag_tck         (jtag_tck),
    .jtag_tms         (jtag_tms),
    .jtag_tdi         (jtag_tdi),
    .jtag_tdo         (jtag_tdo),
    .jtag_tdo_en      (jtag_tdo_en),
    .ir_value         (ir_value),
    .dr_capture_data  (dr_capture_data),
    .dr_update_data   (dr_update_data),
    .dr_update_strobe (dr_update_strobe)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < NDR; k++) strobe_hi[k] = 0;

  always @(negedge clk)
    for (int k = 0; k < NDR; k++)
      if (dr_update_strobe[k] === 1'b1) strobe_hi[k] = strobe_hi[k] + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One TCK period; o is TDO four clk after the falling pin edge.
  task automatic tck_cycle(input logic t, input logic d, output logic o);
    @(negedge clk);
    jtag_tms = t;
    jtag_tdi = d;
    repeat (2) @(negedge clk);
    jtag_tck = 1'b1;
    repeat (5) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (4) @(posedge clk);
    #1 o = jtag_tdo;
  endtask

  task automatic step(input logic t);
    logic o;
    tck_cycle(t, 1'b0, o);
  endtask

  // Expected TDO stream: register of width w captured with cap, fed din.
  function automatic logic [63:0] model_out(int w, logic [63:0] cap, logic [63:0] din, int n);
    logic [127:0] s;
    s = ({64'b0, din} << w) | {64'b0, cap & ((64'd1 << w) - 64'd1)};
    return s[63:0] & ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] model_final(int w, logic [63:0] cap, logic [63:0] din, int n);
    logic [127:0] s;
    s = ({64'b0, din} << w) | {64'b0, cap & ((64'd1 << w) - 64'd1)};
    s = s >> n;
    return s[63:0] & ((64'd1 << w) - 64'd1);
  endfunction

  // Starts and ends in Run-Test/Idle; n may be zero.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o;
    dout = '0;
    step(1'b1);
    if (is_ir) step(1'b1);
    step(1'b0);
    tck_cycle(n == 0, 1'b0, o);
    if (n > 0) begin
      dout[0] = o;
      check("tdo_en_in_shift", 64'(jtag_tdo_en), 64'd1);
    end
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o);
      if (i < n - 1) dout[i+1] = o;
    end
    step(1'b1);
    step(1'b0);
    check("tdo_en_idle", 64'(jtag_tdo_en), 64'd0);
  endtask

  task automatic load_ir(input logic [IRW-1:0] instr);
    logic [63:0] o;
    scan(1'b1, IRW, 64'(instr), o);
    check("ir_capture_out", o, model_out(IRW, 64'd1, 64'(instr), IRW));
    check("ir_value", 64'(ir_value), 64'(instr));
  endtask

  task automatic check_upd();
    for (int k = 0; k < NDR; k++)
      check($sformatf("upd_data_%0d", k), 64'(dr_update_data[k*DRW +: DRW]), 64'(exp_upd[k]));
  endtask

  // Full DR scan against the model for whatever instruction is in the IR.
  task automatic dr_scan_model(input string tag, input logic [IRW-1:0] instr,
                               input int n, input logic [63:0] din);
    int          w;
    logic [63:0] cap, o;
    int          sh [NDR];
    int          uk;
    uk = int'(instr) - 2;
    if (instr == IRW'(1)) begin
      w = 32; cap = 64'(IDC);
    end else if (uk >= 0 && uk < NDR) begin
      w = DRW; cap = 64'(dr_capture_data[uk*DRW +: DRW]);
    end else begin
      w = 1; cap = 64'd0; uk = -1;
    end
    for (int k = 0; k < NDR; k++) sh[k] = strobe_hi[k];
    scan(1'b0, n, din, o);
    check({tag, "_tdo"}, o, model_out(w, cap, din, n));
    if (uk >= 0) exp_upd[uk] = DRW'(model_final(w, cap, din, n));
    for (int k = 0; k < NDR; k++)
      check($sformatf("%s_strobe_%0d", tag, k), 64'(strobe_hi[k] - sh[k]),
            (k == uk) ? 64'd1 : 64'd0);
    check_upd();
  endtask

  initial begin
    logic [63:0]    o, din;
    logic [IRW-1:0] instr;
    int             n, sh [NDR];

    rst = 1'b1;
    jtag_tck = 1'b0; jtag_tms = 1'b0; jtag_tdi = 1'b0;
    dr_capture_data = {$urandom, $urandom};
    for (int k = 0; k < NDR; k++) exp_upd[k] = '0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ir_value", 64'(ir_value), 64'd1);
    check("rst_tdo_en", 64'(jtag_tdo_en), 64'd0);
    check("rst_tdo", 64'(jtag_tdo), 64'd0);
    check("rst_strobe", 64'(dr_update_strobe), 64'd0);
    check_upd();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step(1'b1);
    check("tlr_ir_value", 64'(ir_value), 64'd1);
    check("tlr_tdo_en", 64'(jtag_tdo_en), 64'd0);
    check_upd();
    step(1'b0);

    dr_scan_model("idcode", IRW'(1), 32, 64'd0);
    scan(1'b0, 32, 64'd0, o);
    check("idcode_first_bit", 64'(o[0]), 64'd1);
    check("idcode_value", o, 64'(IDC));

    load_ir('1);
    dr_scan_model("bypass_1011", '1, 4, 64'b1101);
    din = {$urandom, $urandom};
    dr_scan_model("bypass_rand", '1, int'($urandom_range(8, 40)), din);

    load_ir(IRW'(2));
    dr_scan_model("dr0_deadbeef", IRW'(2), 32, 64'hDEADBEEF);
    check("dr0_value", 64'(dr_update_data[31:0]), 64'hDEADBEEF);

    load_ir(IRW'(3));
    dr_capture_data[63:32] = 32'h12345678;
    din = 64'($urandom);
    for (int k = 0; k < NDR; k++) sh[k] = strobe_hi[k];
    fork
      scan(1'b0, 32, din, o);
      begin
        repeat (150) @(negedge clk);
        dr_capture_data[63:32] = $urandom;
      end
    join
    check("dr1_capture_tdo", o, 64'h12345678);
    exp_upd[1] = din[31:0];
    check("dr1_strobe_0", 64'(strobe_hi[0] - sh[0]), 64'd0);
    check("dr1_strobe_1", 64'(strobe_hi[1] - sh[1]), 64'd1);
    check_upd();

    dr_capture_data[63:32] = $urandom;
    dr_scan_model("dr1_zero_len", IRW'(3), 0, 64'd0);

    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 4))
        0:       instr = '0;
        1:       instr = IRW'(1);
        2:       instr = IRW'(2);
        3:       instr = IRW'(3);
        default: instr = IRW'($urandom_range(4, 31));
      endcase
      dr_capture_data = {$urandom, $urandom};
      load_ir(instr);
      din = {$urandom, $urandom};
      n = int'($urandom_range(0, 40));
      dr_scan_model($sformatf("rand%0d", it), instr, n, din);
    end

    // Five TMS=1 edges from mid Shift-DR reach Test-Logic-Reset.
    load_ir('0);
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);
    check("tms5_ir_value", 64'(ir_value), 64'd1);
    check("tms5_tdo_en", 64'(jtag_tdo_en), 64'd0);
    check_upd();
    step(1'b0);

    // Reset mid-shift, coincident with a TCK rising edge.
    load_ir(IRW'(2));
    for (int k = 0; k < NDR; k++) sh[k] = strobe_hi[k];
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 16; i++) step(1'b0);
    @(negedge clk);
    jtag_tms = 1'b1;
    rst = 1'b1;
    jtag_tck = 1'b1;
    repeat (5) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NDR; k++) exp_upd[k] = '0;
    check("rstmid_ir_value", 64'(ir_value), 64'd1);
    check("rstmid_tdo_en", 64'(jtag_tdo_en), 64'd0);
    check("rstmid_tdo", 64'(jtag_tdo), 64'd0);
    for (int k = 0; k < NDR; k++)
      check($sformatf("rstmid_strobe_%0d", k), 64'(strobe_hi[k] - sh[k]), 64'd0);
    check_upd();
    step(1'b0);
    dr_scan_model("post_rst_idcode", IRW'(1), 32, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
Name: jtag_tap_core

Overview:
- Complete JTAG TAP running in the system clock domain. Generalises the single load/shift register into a full IEEE 1149.1 test access port.
- Contains: TCK/TMS/TDI synchroniser, 16-state TAP FSM, instruction register, BYPASS, IDCODE, and NUM_DR user data registers, each with a capture input and an update shadow output.
- Sits between the chip-level JTAG pins and debug/config logic in the core.

Parameters:
- IR_WIDTH, 5, instruction register width (>=2).
- DR_WIDTH, 32, width of each user data register (>=1).
- NUM_DR, 2, number of user data registers (>=1, 2+NUM_DR <= 2^IR_WIDTH-1).
- IDCODE_VALUE, 32'h00000001, IDCODE contents (bit0 must be 1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- jtag_tck  in  1  asynchronous TCK pin
- jtag_tms  in  1  asynchronous TMS pin
- jtag_tdi  in  1  asynchronous TDI pin
- jtag_tdo  out  1  TDO data
- jtag_tdo_en  out  1  high while in Shift-DR or Shift-IR
- ir_value  out  IR_WIDTH  current (updated) instruction
- dr_capture_data  in  NUM_DR*DR_WIDTH  parallel capture values; register k at bits [k*DR_WIDTH +: DR_WIDTH]
- dr_update_data  out  NUM_DR*DR_WIDTH  update shadow registers, same packing
- dr_update_strobe  out  NUM_DR  one-clk pulse when register k is updated

Behaviour:
- Reset: the clock is clk; reset rst is synchronous and active-high. On reset:
  - FSM = Test-Logic-Reset; ir_value = IDCODE instruction (1).
  - All shift registers and dr_update_data = 0.
  - jtag_tdo = 0, jtag_tdo_en = 0, dr_update_strobe = 0.
- Synchroniser:
  - tck/tms/tdi each pass through 2 flops. tck also has a third flop for edge detection.
  - tck_rise/tck_fall are one-clk pulses, 3 clk after the pin edge.
  - tms/tdi are sampled from the synced copies on tck_rise.
  - Requires clk >= 4x TCK frequency.
- FSM:
  - Standard 16-state IEEE 1149.1 graph; advances only on tck_rise using synced TMS.
  - 5 consecutive tck_rise with TMS=1 reach Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset forces ir_value to IDCODE.
- Instruction decode (from ir_value):
  - 1 = IDCODE.
  - all-ones = BYPASS.
  - 2+k = user DR k, for k < NUM_DR.
  - 0 and any other value = BYPASS.
- Capture: on tck_rise while in the Capture state:
  - Capture-IR: IR shift <= {0...,2'b01}.
  - Capture-DR: selected shift reg <= IDCODE_VALUE, 1'b0 (bypass), or dr_capture_data slice k.
- Shift: on tck_rise while in the Shift state:
  - Selected shift reg <= {tdi, sr[W-1:1]}, i.e. LSB-first.
  - Only the selected register shifts.
- TDO:
  - Updated on tck_fall to sr[0] of the selected register (IR register in IR states).
  - jtag_tdo_en follows the FSM state on the same tck_fall.
  - TDO holds its value outside shift states.
- Update: on tck_fall while in Update-IR or Update-DR:
  - Update-IR: ir_value <= IR shift.
  - Update-DR: for user DR k, dr_update_data slice k <= shift reg k and dr_update_strobe[k] pulses high for exactly one clk.
  - IDCODE/BYPASS: no update action.
- Boundary conditions:
  - Zero-length shift (Capture -> Exit1 -> Update) writes the captured value back unchanged, and the strobe still fires.
  - dr_capture_data is sampled only at Capture; changes during Shift are ignored.
  - Coincident tck_rise and rst: rst wins.
  - rst mid-shift aborts the shift; dr_update_data is not modified except by clearing to 0.
- Latency: a TDO change is visible at most 4 clk after the falling pin edge of TCK.

Decomposition:
- Shared package jtag_pkg:
  - TAP state enum (4-bit, TEST_LOGIC_RESET = 4'hF, standard encodings).
  - Instruction constants INSTR_IDCODE and INSTR_BYPASS, and INSTR_DR_BASE = 2.
- One natural sub-module: jtag_sync_edge.
  - 2-flop synchroniser plus edge detector.
  - Instantiated once for tck, emitting rise/fall pulses.
  - Plain 2-flop instances for tms/tdi.
- TAP FSM and register bank stay in jtag_tap_core.

Test Plan:
- rst then 5 TCK cycles with TMS=1 -> state Test-Logic-Reset, ir_value=1, jtag_tdo_en=0, all dr_update_data=0.
- From reset go to Shift-DR, clock 32 bits with TDI=0 -> TDO stream LSB-first equals IDCODE_VALUE (first bit 1).
- Load IR=all-ones, shift TDI pattern 1011 through DR -> TDO reproduces the pattern delayed by 1 TCK, first bit 0.
- Load IR=2 and shift 0xDEADBEEF, then Update-DR -> dr_update_data[31:0]=0xDEADBEEF, dr_update_strobe=2'b01 for exactly one clk, DR1 slice unchanged.
- IR=3, dr_capture_data[63:32]=0x12345678, Capture->Shift 32 bits -> TDO yields 0x12345678; Shift-IR output begins with 1,0.
- Assert rst midway through a 32-bit DR2 shift -> FSM in Test-Logic-Reset, no strobe, dr_update_data cleared to 0, ir_value=1.
